atax_operand_streamer: RTL and testbench

Transmit-side companion to the ATAX kernel's operand input. On a start pulse it reads vector x, then matrix A (row-major), from a synchronous-read scratchpad. It packs the elements into LANES-wide beats and streams them over a valid/ready interface. The kernel's operand receiver or a downstream DMA consumes the stream. Sits between the scratchpad and the kernel's input port.

---
 rtl/atax_pkg.sv | 18 +
 rtl/atax_operand_streamer_if.sv | 30 +++
 rtl/atax_beat_fifo.sv | 50 +++++
 rtl/atax_operand_streamer.sv | 216 +++++++++++++++++++++
 tb/tb_atax_operand_streamer.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/atax_pkg.sv
// Shared definitions for the ATAX operand streamer: default sizes, beat-kind
// encoding and the transfer sequencing states.
package atax_pkg;

    localparam int ATAX_ELEM_W = 32;
    localparam int ATAX_N      = 64;

    localparam logic KIND_X = 1'b0;
    localparam logic KIND_A = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_X,
        ST_SEND_A,
        ST_DRAIN
    } atax_state_e;

endpackage

// File: rtl/atax_operand_streamer_if.sv
// Beat stream from the operand streamer to the kernel / DMA (valid/ready).
interface atax_operand_streamer_if #(
    parameter int LANES  = 2,
    parameter int ELEM_W = 32
);
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*ELEM_W-1:0]   out_data;
    logic                      out_kind;
    logic                      out_row_last;
    logic                      out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_kind,
        output out_row_last,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_kind,
        input  out_row_last,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/atax_beat_fifo.sv
// Two-entry beat FIFO; the head entry stays put until it is popped, so the
// stream output is stable under back-pressure.
module atax_beat_fifo #(
    parameter int W = 67
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);
    logic [W-1:0] entry_reg [2];
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [1:0]   count_reg;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count_reg != 2'd0);
    assign do_push = push && ((count_reg != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                entry_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                entry_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg            <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = entry_reg[rd_ptr_reg];
    assign count     = count_reg;
endmodule

// File: rtl/atax_operand_streamer.sv
// Reads x then A (row-major) from a synchronous-read scratchpad, packs the
// elements into LANES-wide beats and streams them with kind/row/last tags.
module atax_operand_streamer
    import atax_pkg::*;
#(
    parameter int N      = ATAX_N,
    parameter int ELEM_W = ATAX_ELEM_W,
    parameter int LANES  = 2,
    parameter int ADDR_W = 13,
    parameter int BASE_X = 0,
    parameter int BASE_A = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [ELEM_W-1:0] mem_rdata,
    atax_operand_streamer_if.master strm
);
    localparam int BEATS_PER_ROW = N / LANES;
    localparam int TOTAL         = N + N * N;
    localparam int IDX_W         = $clog2(TOTAL + 1);
    localparam int LANE_W        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int COL_W         = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
    localparam int ROW_W         = $clog2(N + 1);
    localparam int DATA_W        = LANES * ELEM_W;
    localparam int PAY_W         = DATA_W + 3;

    generate
        if (N % LANES != 0) begin : g_bad_lanes
            $error("atax_operand_streamer: N must be a multiple of LANES");
        end
        if (BASE_A + N * N - 1 >= (1 << ADDR_W)) begin : g_bad_addr_w
            $error("atax_operand_streamer: ADDR_W too small for matrix A");
        end
    endgenerate

    atax_state_e       state_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              rd_en_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [IDX_W-1:0]  rd_idx_reg;
    logic [LANE_W-1:0] iss_lane_reg;
    logic [1:0]        ob_reg;
    logic              rd_pending_reg;
    logic [LANE_W-1:0] asm_lane_reg;
    logic [ELEM_W-1:0] asm_reg [LANES];
    logic [COL_W-1:0]  beat_col_reg;
    logic [ROW_W-1:0]  beat_row_reg;

    logic              fifo_push;
    logic              fifo_pop;
    logic [1:0]        fifo_count;
    logic [PAY_W-1:0]  push_payload;
    logic [PAY_W-1:0]  head_payload;
    logic [DATA_W-1:0] beat_data;
    logic              beat_kind;
    logic              beat_row_last;
    logic              beat_last;
    logic              last_lane;
    logic [2:0]        occ_after;
    logic [1:0]        ob_after_push;
    logic              room_new_beat;
    logic              want_issue;
    logic              issue;
    logic              new_beat;
    logic [ADDR_W-1:0] next_addr;

    assign last_lane = (asm_lane_reg == LANE_W'(LANES - 1));
    assign fifo_push = rd_pending_reg && last_lane;
    assign fifo_pop  = strm.out_valid && strm.out_ready;

    // A beat slot is reserved when its first read is issued and released when
    // the beat leaves the FIFO. A read that starts a new beat needs a free
    // slot after this cycle's push/pop; reads filling an open beat always go.
    assign occ_after     = {1'b0, fifo_count} + {2'b00, fifo_push} - {2'b00, fifo_pop};
    assign ob_after_push = ob_reg - {1'b0, fifo_push};
    assign room_new_beat = (occ_after + {1'b0, ob_after_push}) < 3'd2;

    assign want_issue = ((state_reg == ST_IDLE) && start)
                      || (state_reg == ST_SEND_X)
                      || (state_reg == ST_SEND_A);
    assign issue      = want_issue && ((iss_lane_reg != '0) || room_new_beat);
    assign new_beat   = issue && (iss_lane_reg == '0);

    always_comb begin
        next_addr = '0;
        if (rd_idx_reg < IDX_W'(N)) begin
            next_addr = ADDR_W'(BASE_X) + ADDR_W'(rd_idx_reg);
        end else begin
            next_addr = ADDR_W'(BASE_A) + ADDR_W'(rd_idx_reg) - ADDR_W'(N);
        end
    end

    // The top lane comes straight from the scratchpad so the beat is pushed in
    // the same cycle its last element returns.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_pack
            if (gi == LANES - 1) begin : g_top
                assign beat_data[gi*ELEM_W +: ELEM_W] = mem_rdata;
            end else begin : g_low
                assign beat_data[gi*ELEM_W +: ELEM_W] = asm_reg[gi];
            end
        end
    endgenerate

    assign beat_kind     = (beat_row_reg != '0) ? KIND_A : KIND_X;
    assign beat_row_last = (beat_col_reg == COL_W'(BEATS_PER_ROW - 1));
    assign beat_last     = (beat_row_reg == ROW_W'(N)) && beat_row_last;
    assign push_payload  = {beat_last, beat_row_last, beat_kind, beat_data};

    atax_beat_fifo #(
        .W(PAY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_payload),
        .pop       (fifo_pop),
        .head_data (head_payload),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            rd_en_reg      <= 1'b0;
            addr_reg       <= '0;
            rd_idx_reg     <= '0;
            iss_lane_reg   <= '0;
            ob_reg         <= '0;
            rd_pending_reg <= 1'b0;
            asm_lane_reg   <= '0;
            for (int i = 0; i < LANES; i++) begin
                asm_reg[i] <= '0;
            end
            beat_col_reg   <= '0;
            beat_row_reg   <= '0;
        end else begin
            done_reg       <= 1'b0;
            rd_en_reg      <= issue;
            rd_pending_reg <= rd_en_reg;
            ob_reg         <= ob_reg + {1'b0, new_beat} - {1'b0, fifo_push};

            if (issue) begin
                addr_reg     <= next_addr;
                rd_idx_reg   <= rd_idx_reg + IDX_W'(1);
                iss_lane_reg <= (iss_lane_reg == LANE_W'(LANES - 1)) ? '0
                                : iss_lane_reg + LANE_W'(1);
            end

            if (rd_pending_reg) begin
                asm_reg[asm_lane_reg] <= mem_rdata;
                asm_lane_reg <= last_lane ? '0 : asm_lane_reg + LANE_W'(1);
            end

            if (fifo_push) begin
                if (beat_last) begin
                    beat_row_reg <= '0;
                    beat_col_reg <= '0;
                end else if (beat_row_last) begin
                    beat_row_reg <= beat_row_reg + ROW_W'(1);
                    beat_col_reg <= '0;
                end else begin
                    beat_col_reg <= beat_col_reg + COL_W'(1);
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= (N == 1) ? ST_SEND_A : ST_SEND_X;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_SEND_X: begin
                    if (issue && (rd_idx_reg == IDX_W'(N - 1))) begin
                        state_reg <= ST_SEND_A;
                    end
                end
                ST_SEND_A: begin
                    if (issue && (rd_idx_reg == IDX_W'(TOTAL - 1))) begin
                        state_reg  <= ST_DRAIN;
                        rd_idx_reg <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_pop && strm.out_last) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign mem_rd_en = rd_en_reg;
    assign mem_addr  = addr_reg;

    assign strm.out_valid    = (fifo_count != 2'd0);
    assign strm.out_data     = head_payload[DATA_W-1:0];
    assign strm.out_kind     = head_payload[DATA_W];
    assign strm.out_row_last = head_payload[DATA_W+1];
    assign strm.out_last     = head_payload[DATA_W+2];
endmodule

// File: tb/tb_atax_operand_streamer.sv
// Bench for atax_operand_streamer with N=4, LANES=2 and a scratchpad holding
// word k = k; a beat scoreboard is filled from a hand-written expected table.
module tb_atax_operand_streamer;
    localparam int N      = 4;
    localparam int ELEM_W = 32;
    localparam int LANES  = 2;
    localparam int ADDR_W = 13;
    localparam int BASE_X = 0;
    localparam int BASE_A = 64;
    localparam int NBEATS = (N + N * N) / LANES;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  side;   // {last, row_last, kind}
    } beat_t;

    typedef struct {
        int ready_mode;      // 0: always ready, 1: toggle, 2: held low
        int stall;
        bit timing;
    } scen_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [ELEM_W-1:0] mem_rdata;

    atax_operand_streamer_if #(.LANES(LANES), .ELEM_W(ELEM_W)) strm_if ();

    atax_operand_streamer #(
        .N(N), .ELEM_W(ELEM_W), .LANES(LANES),
        .ADDR_W(ADDR_W), .BASE_X(BASE_X), .BASE_A(BASE_A)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .strm      (strm_if)
    );

    int    errors = 0;
    int    checks = 0;
    int    ready_mode = 0;
    int    rd_count = 0;
    int    hs_count = 0;
    int    done_count = 0;
    bit    expect_done = 0;
    bit    stalled_prev = 0;
    logic [66:0] prev_head;
    beat_t beat_tab [NBEATS];
    scen_t scen_tab [3];
    beat_t sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= ELEM_W'(mem_addr);
    end

    function automatic void check(string name, logic [79:0] act, logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    initial begin
        strm_if.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       strm_if.out_ready = 1'b1;
                1:       strm_if.out_ready = ~strm_if.out_ready;
                default: strm_if.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: one line per consumed beat, scoreboard compare, stall stability,
    // read window and done timing.
    always @(negedge clk) begin
        if (reset) begin
            stalled_prev = 0;
            expect_done  = 0;
        end else begin
            if (expect_done) begin
                check("done_after_last", done, 1);
                expect_done = 0;
            end else if (done) begin
                check("spurious_done", done, 0);
            end
            if (done) done_count++;
            if (mem_rd_en) begin
                rd_count++;
                check("read_window", (rd_count - LANES * hs_count) <= 2 * LANES, 1);
            end
            if (stalled_prev) begin
                check("stall_valid_hold", strm_if.out_valid, 1);
                check("stall_head_hold", {strm_if.out_last, strm_if.out_row_last,
                      strm_if.out_kind, strm_if.out_data}, prev_head);
            end
            if (strm_if.out_valid && strm_if.out_ready) begin
                beat_t exp_b;
                $display("beat %0d: data=%h kind=%0b row_last=%0b last=%0b",
                         hs_count, strm_if.out_data, strm_if.out_kind,
                         strm_if.out_row_last, strm_if.out_last);
                hs_count++;
                if (sb.size() == 0) begin
                    check("unexpected_beat", strm_if.out_data, 0);
                    errors++;
                    checks++;
                    $display("FAIL no_expected_beat: got beat with none expected");
                end else begin
                    exp_b = sb.pop_front();
                    check("beat_data", strm_if.out_data, exp_b.data);
                    check("beat_side", {strm_if.out_last, strm_if.out_row_last,
                          strm_if.out_kind}, exp_b.side);
                end
                if (strm_if.out_last) expect_done = 1;
            end
            stalled_prev = strm_if.out_valid && !strm_if.out_ready;
            prev_head = {strm_if.out_last, strm_if.out_row_last, strm_if.out_kind,
                         strm_if.out_data};
        end
    end

    task automatic load_sb();
        for (int i = 0; i < NBEATS; i++) sb.push_back(beat_tab[i]);
    endtask

    task automatic do_start();
        @(posedge clk);
        #1;
        rd_count = 0;
        hs_count = 0;
        load_sb();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic end_of_transfer(input string name);
        check({name, "_sb_empty"}, sb.size(), 0);
        check({name, "_beats"}, hs_count, NBEATS);
        check({name, "_reads"}, rd_count, N + N * N);
    endtask

    initial begin
        // Expected beats: lane 0 in the low word, side = {last, row_last, kind}
        beat_tab[0] = '{64'h00000001_00000000, 3'b000};
        beat_tab[1] = '{64'h00000003_00000002, 3'b010};
        beat_tab[2] = '{64'h00000041_00000040, 3'b001};
        beat_tab[3] = '{64'h00000043_00000042, 3'b011};
        beat_tab[4] = '{64'h00000045_00000044, 3'b001};
        beat_tab[5] = '{64'h00000047_00000046, 3'b011};
        beat_tab[6] = '{64'h00000049_00000048, 3'b001};
        beat_tab[7] = '{64'h0000004b_0000004a, 3'b011};
        beat_tab[8] = '{64'h0000004d_0000004c, 3'b001};
        beat_tab[9] = '{64'h0000004f_0000004e, 3'b111};
        scen_tab[0] = '{0, 0, 1'b1};
        scen_tab[1] = '{1, 0, 1'b0};
        scen_tab[2] = '{2, 20, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_valid", strm_if.out_valid, 0);
        check("rst_data", strm_if.out_data, 0);
        check("rst_side", {strm_if.out_last, strm_if.out_row_last, strm_if.out_kind}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int s = 0; s < 3; s++) begin
            ready_mode = (scen_tab[s].ready_mode == 2) ? 2 : 0;
            do_start();
            if (scen_tab[s].ready_mode == 1) ready_mode = 1;
            if (scen_tab[s].timing) begin
                int n = 0;
                @(negedge clk);
                check("first_read_en", mem_rd_en, 1);
                check("first_read_addr", mem_addr, BASE_X);
                check("busy_after_start", busy, 1);
                while (!strm_if.out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("first_valid_latency", n, LANES + 1);
                while (done !== 1'b1 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check("done_cycle", n, (LANES + 1) + (NBEATS - 1) * LANES + 1);
                check("busy_low_with_done", busy, 0);
            end else begin
                if (scen_tab[s].stall > 0) begin
                    repeat (scen_tab[s].stall) @(posedge clk);
                    #1;
                    check("stall_reads_bounded", rd_count <= 2 * LANES, 1);
                    check("stall_no_beats", hs_count, 0);
                    check("stall_valid", strm_if.out_valid, 1);
                    ready_mode = 0;
                end
                wait_done($sformatf("scen%0d_done", s + 1), 400);
            end
            @(posedge clk);
            #1;
            end_of_transfer($sformatf("scen%0d", s + 1));
            ready_mode = 0;
        end

        // Start pulsed mid-transfer is ignored
        begin
            int dc0;
            dc0 = done_count;
            do_start();
            repeat (8) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            wait_done("midstart_done", 400);
            repeat (20) @(posedge clk);
            #1;
            end_of_transfer("midstart");
            check("midstart_done_count", done_count - dc0, 1);
            check("midstart_idle_valid", strm_if.out_valid, 0);
            check("midstart_idle_busy", busy, 0);
        end

        // Reset after the fifth beat
        begin
            int n = 0;
            do_start();
            while (hs_count < 5 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("reset_reached_beat5", hs_count >= 5, 1);
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("midrst_busy", busy, 0);
            check("midrst_rd_en", mem_rd_en, 0);
            check("midrst_addr", mem_addr, 0);
            check("midrst_valid", strm_if.out_valid, 0);
            check("midrst_data", strm_if.out_data, 0);
            check("midrst_side", {strm_if.out_last, strm_if.out_row_last, strm_if.out_kind}, 0);
            sb.delete();
            @(posedge clk);
            #1;
            reset = 1'b0;
            do_start();
            wait_done("after_reset_done", 400);
            @(posedge clk);
            #1;
            end_of_transfer("after_reset");
        end

        // Start in the same cycle as done is accepted
        begin
            do_start();
            wait_done("b2b_first_done", 400);
            check("b2b_done_high", done, 1);
            load_sb();
            start = 1'b1;
            @(posedge clk);
            #1;
            rd_count = 0;
            hs_count = 0;
            start = 1'b0;
            @(negedge clk);
            check("b2b_first_read_en", mem_rd_en, 1);
            check("b2b_first_read_addr", mem_addr, BASE_X);
            wait_done("b2b_second_done", 400);
            @(posedge clk);
            #1;
            check("b2b_sb_empty", sb.size(), 0);
            check("b2b_beats", hs_count, NBEATS);
        end

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
